serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract unit built around a single one-bit full-add step (two cascaded half-add stages plus a carry flop). An FSM loads two WIDTH-bit operands and processes one bit per cycle, LSB first, through the shared one-bit datapath. It presents the result with a start/busy/done handshake. It is the area-lean arithmetic option for the lab datapath, where WIDTH-cycle latency is acceptable.

---
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract, one bit per cycle, LSB first.
// Ports: clk, rst (async, active-high), start/sub/a_in/b_in request side;
//        busy/done/sum_out/carry_out registered result side.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Shared one-bit datapath: two half-add stages around the carry flop.
    logic p, g, s, c_nxt;
    assign p     = a_q[0] ^ b_q[0];
    assign g     = a_q[0] & b_q[0];
    assign s     = p ^ c_q;
    assign c_nxt = g | (p & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B, carry-in of 1.
                    a_d     = a_in;
                    b_d     = sub ? ~b_in : b_in;
                    c_d     = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {s, res_q[WIDTH-1:1]};
                c_d   = c_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = {s, res_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;
    assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl
// at WIDTH=8 and WIDTH=13 against an arithmetic reference model.
module tb_serial_adder_ctrl;
    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        sel13 = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;

    logic        busy8, done8, c8;
    logic [7:0]  s8;
    logic        busy13, done13, c13;
    logic [12:0] s13;

    logic        busy_w, done_w, cout_w;
    logic [31:0] sum_w;

    int errs   = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start & ~sel13), .sub(sub),
        .a_in(a[7:0]), .b_in(b[7:0]), .busy(busy8), .done(done8),
        .sum_out(s8), .carry_out(c8)
    );

    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start & sel13), .sub(sub),
        .a_in(a[12:0]), .b_in(b[12:0]), .busy(busy13), .done(done13),
        .sum_out(s13), .carry_out(c13)
    );

    always #5 clk = ~clk;

    always_comb begin
        busy_w = sel13 ? busy13 : busy8;
        done_w = sel13 ? done13 : done8;
        cout_w = sel13 ? c13 : c8;
        sum_w  = sel13 ? {19'b0, s13} : {24'b0, s8};
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {carry,sum} = a + (sub ? ~b : b) + sub, modulo 2^(w+1).
    function automatic logic [32:0] model(input int w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic sv);
        logic [32:0] m, bb;
        m  = (33'd1 << w) - 33'd1;
        bb = sv ? (~{1'b0, bv} & m) : ({1'b0, bv} & m);
        return ({1'b0, av} & m) + bb + 33'(sv);
    endfunction

    task automatic op(input logic [31:0] av, input logic [31:0] bv,
                      input logic sv);
        int          w, n, bc;
        logic [32:0] r, m;
        logic [31:0] prev;
        bit          stable;
        w = sel13 ? 13 : 8;
        m = (33'd1 << w) - 33'd1;
        r = model(w, av, bv, sv);
        a = av; b = bv; sub = sv;
        prev = sum_w; stable = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1; bc = int'(busy_w);
        while (!done_w && n < 60) begin
            if (sum_w !== prev) stable = 0;
            tick();
            n++;
            bc += int'(busy_w);
        end
        check("latency", 64'(n), 64'(w + 1));
        check("sum", 64'(sum_w), 64'(r & m));
        check("cout", 64'(cout_w), 64'(r[w]));
        check("stable", 64'(stable), 64'd1);
        check("busy_in_done", 64'(busy_w), 64'd1);
        tick();
        check("done_pulse", 64'(done_w), 64'd0);
        check("busy_len", 64'(bc + int'(busy_w)), 64'(w + 1));
    endtask

    initial begin
        int dk[$];
        int n, bc, nd, dn;
        #12;
        check("rst_busy", 64'(busy_w), 64'd0);
        check("rst_done", 64'(done_w), 64'd0);
        check("rst_sum", 64'(sum_w), 64'd0);
        check("rst_cout", 64'(cout_w), 64'd0);
        check("rst_busy13", 64'(busy13), 64'd0);
        tick();
        rst = 1'b0;

        op(32'h5A, 32'h3C, 1'b0);
        op(32'hFF, 32'h01, 1'b0);
        op(32'h20, 32'h10, 1'b1);
        op(32'h10, 32'h20, 1'b1);
        op(32'h00, 32'h00, 1'b1);
        check("sub00_cout", 64'(cout_w), 64'd1);

        // Requests while busy (mid-RUN and in DONE) must be dropped.
        a = 32'h01; b = 32'h01; sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        bc = int'(busy_w); nd = 0; dn = 0;
        for (int k = 2; k <= 14; k++) begin
            start = (k == 4) || done_w;
            if (k == 4) begin
                a = 32'hAA; b = 32'h55;
            end
            tick();
            bc += int'(busy_w);
            nd += int'(done_w);
            if (done_w) dn = k;
        end
        start = 1'b0;
        check("ign_ndone", 64'(nd), 64'd1);
        check("ign_done_at", 64'(dn), 64'd9);
        check("ign_busy_len", 64'(bc), 64'd9);
        check("ign_sum", 64'(sum_w), 64'h02);

        // Start held high: one operation every WIDTH+2 cycles.
        a = 32'h80; b = 32'h80; sub = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            if (k == 26) start = 1'b0;
            tick();
            if (done_w) begin
                dk.push_back(k);
                check("held_sum", 64'(sum_w), 64'h00);
                check("held_cout", 64'(cout_w), 64'd1);
            end
        end
        check("held_n", 64'(dk.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check("held_at", 64'(i < dk.size() ? dk[i] : -1), 64'(9 + 10 * i));

        // Asynchronous reset in the middle of an operation.
        op(32'h12, 32'h34, 1'b0);
        a = 32'hF0; b = 32'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy_w), 64'd0);
        check("arst_done", 64'(done_w), 64'd0);
        check("arst_sum", 64'(sum_w), 64'd0);
        check("arst_cout", 64'(cout_w), 64'd0);
        tick(); tick();
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            nd += int'(done_w);
        end
        check("arst_nodone", 64'(nd), 64'd0);
        op(32'h01, 32'h02, 1'b0);
        check("arst_after", 64'(sum_w), 64'h03);

        for (int i = 0; i < 1000; i++)
            op($urandom() & 32'hFF, $urandom() & 32'hFF, 1'($urandom_range(0, 1)));

        sel13 = 1'b1;
        tick();
        op(32'h1FFF, 32'h0001, 1'b0);
        op(32'h0000, 32'h0001, 1'b1);
        for (int i = 0; i < 1000; i++)
            op($urandom() & 32'h1FFF, $urandom() & 32'h1FFF,
               1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
